pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor with carry-in/borrow-in, carry-out and signed-overflow flags, and a valid/ready stream interface on both sides. Operands are split into SLICE-bit ripple slices, with one slice per pipeline stage and the carry registered between stages. It is the general arithmetic datapath element for wide operands where a single-cycle ripple chain would not meet timing.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2 and an integer multiple of SLICE.
- SLICE, 4: bits resolved per pipeline stage; STAGES = WIDTH/SLICE.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  add: carry-in; subtract: borrow-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  signed overflow.

## Operation
- Add: sum = A + B + cin.
- Subtract: sum = A + ~B + ~cin, i.e. A − B − cin.
- All arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH−1.
- ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the effective operand (~B in subtract mode).
- Stage k (0..STAGES−1) resolves bits [k·SLICE +: SLICE] using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Unconsumed operand bits are delayed alongside the data. Resolved sum slices are delayed so all slices align at the output.
- The sub flag travels with its beat, so mode may change on every beat.
- Each stage holds a valid bit. Empty stages are bubbles and produce no output.
- Flow control is a global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance = 0, every stage register holds its value.
- A beat is accepted when in_valid && in_ready. Results emerge in acceptance order; no beat is dropped or duplicated.

## Timing
- Latency is STAGES cycles from acceptance to out_valid = 1, when there is no stall (2 cycles at the defaults).
- Throughput is one beat per cycle while out_ready = 1.
- in_ready is combinational from out_ready and the last-stage valid bit. No other combinational in→out path exists.
- sum, cout, ovf and out_valid are registered and stay stable while out_valid && !out_ready.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation discards every in-flight beat. No result from a pre-reset beat ever appears.
- While rst = 1, in_ready = 0 and input beats are ignored.
- Simultaneous output consume and input accept in the same cycle is legal: the pipeline shifts by one.
- Data-path registers of bubble stages may hold stale values. Only valid-qualified values are observable.

## Structure
- Package add_sub_pkg holds a function computing STAGES and the legality check (WIDTH % SLICE == 0, elaboration-time error otherwise).
- Sub-module add_slice: a combinational SLICE-bit ripple adder.
  - Inputs: a, b, cin. Outputs: s, cout, plus the MSB-carry-in needed for ovf.
  - Instantiated once per stage. The enclosing module owns all registers and the valid/stall logic.
- Expected size is about 150–250 RTL lines.

## Test plan
All scenarios use the defaults (WIDTH = 8, SLICE = 4).
- Add with overflow: a=0x7F, b=0x01, sub=0, cin=0 → two cycles later sum=0x80, cout=0, ovf=1.
- Add with carry-in: a=0xFF, b=0x01, sub=0, cin=1 → sum=0x01, cout=1, ovf=0.
- Subtract with borrow: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0, ovf=0.
- Subtract with overflow: a=0x80, b=0x01, sub=1, cin=0 → sum=0x7F, cout=1, ovf=1.
- Backpressure: stream 5 back-to-back beats with alternating sub, and hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0 during the stall, outputs stay stable, and all 5 results arrive in order with no gaps after release. Compare against a reference model.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle → out_valid stays 0 until new beats are accepted, then the first result appears exactly STAGES cycles after its acceptance.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - stage count and parameter legality helpers for pipelined_add_sub
package add_sub_pkg;

  // Number of pipeline stages: one SLICE-bit ripple slice per stage.
  function automatic int add_sub_stages(input int width, input int slice);
    return width / slice;
  endfunction

  // Operands must be at least 2 bits and split evenly into slices.
  function automatic bit add_sub_legal(input int width, input int slice);
    return (width >= 2) && (slice >= 1) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result stream bundle for pipelined_add_sub
interface pipelined_add_sub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Arithmetic block side.
  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_add_sub_slice.sv
// rtl/pipelined_add_sub_slice.sv - combinational SLICE-bit ripple adder
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [SLICE:0] c;

  // Ripple the carry bit by bit; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout    = c[SLICE];
  assign msb_cin = c[SLICE-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined add/subtract with carry, overflow and stall flow control
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic                clk,
  input  logic                rst,
  pipelined_add_sub_if.slave  bus
);

  localparam int STAGES = add_sub_stages(WIDTH, SLICE);

  if (!add_sub_legal(WIDTH, SLICE)) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of SLICE");
  end

  // Per-stage registers. a_r/b_r carry operand bits still to be resolved
  // (b_r already holds the effective operand, so the add/sub mode travels
  // with the beat); s_r accumulates the resolved sum slices.
  logic [STAGES-1:0] v_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic              c_r [STAGES];
  logic              ovf_r;

  logic advance;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance      = !v_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance && !rst;

  assign bus.out_valid = v_r[STAGES-1];
  assign bus.sum       = s_r[STAGES-1];
  assign bus.cout      = c_r[STAGES-1];
  assign bus.ovf       = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic [SLICE-1:0] s_slice;
    logic             c_slice;
    logic             m_slice;
    logic [WIDTH-1:0] s_next;

    if (k == 0) begin : g_first
      // Stage 0 forms the effective operand and carry from the raw inputs.
      assign v_src = bus.in_valid;
      assign a_src = bus.a;
      assign b_src = bus.sub ? ~bus.b : bus.b;
      assign c_src = bus.sub ? ~bus.cin : bus.cin;
      assign s_src = '0;
    end else begin : g_next
      assign v_src = v_r[k-1];
      assign a_src = a_r[k-1];
      assign b_src = b_r[k-1];
      assign c_src = c_r[k-1];
      assign s_src = s_r[k-1];
    end

    add_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a       (a_src[k*SLICE +: SLICE]),
      .b       (b_src[k*SLICE +: SLICE]),
      .cin     (c_src),
      .s       (s_slice),
      .cout    (c_slice),
      .msb_cin (m_slice)
    );

    // Merge this stage's resolved slice into the partial sum.
    always_comb begin
      s_next                    = s_src;
      s_next[k*SLICE +: SLICE]  = s_slice;
    end

    // Stage register: cleared on reset, held while stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end else if (advance) begin
        v_r[k] <= v_src;
        a_r[k] <= a_src;
        b_r[k] <= b_src;
        s_r[k] <= s_next;
        c_r[k] <= c_slice;
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance) begin
          ovf_r <= m_slice ^ c_slice;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - directed self-checking bench for pipelined_add_sub
module tb_pipelined_add_sub;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  pipelined_add_sub_if #(.WIDTH(8)) bus ();

  pipelined_add_sub #(
    .WIDTH (8),
    .SLICE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic s, input logic c);
    logic [7:0] bb;
    logic [8:0] full;
    logic       cc;
    logic       ov;
    bb   = s ? ~b : b;
    cc   = s ? ~c : c;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
    ov   = (a[7] == bb[7]) && (full[7] != a[7]);
    return {ov, full[8], full[7:0]};
  endfunction

  // Single isolated beat: accept, then expect the result exactly two cycles later.
  task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
    bus.a         = a;
    bus.b         = b;
    bus.sub       = s;
    bus.cin       = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_early"}, bus.out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_sum"}, bus.sum, es);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_ovf"}, bus.ovf, eo);
    @(posedge clk); #1;
    check({tag, "_drained"}, bus.out_valid, 0);
  endtask

  logic [7:0] va [5];
  logic [7:0] vb [5];
  logic       vs [5];
  logic       vc [5];
  logic [9:0] held;

  initial begin
    int sent;
    int got;
    int stall;
    bit acc;

    n_vec = 0;
    n_bad = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);

    // Directed vectors with hand-computed results.
    run_vec("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_vec("add_cin", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    run_vec("sub_brw", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_vec("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_vec("sub_bin", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
    run_vec("add_cross", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    // Backpressure: 5 back-to-back beats, 3-cycle stall once out_valid rises.
    va = '{8'h12, 8'h50, 8'h7F, 8'h00, 8'hC8};
    vb = '{8'h34, 8'h60, 8'h7F, 8'h01, 8'h9C};
    vs = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    vc = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    sent  = 0;
    got   = 0;
    stall = 0;
    held  = '0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      bus.in_valid = (sent < 5);
      if (sent < 5) begin
        bus.a   = va[sent];
        bus.b   = vb[sent];
        bus.sub = vs[sent];
        bus.cin = vc[sent];
      end
      if (bus.out_valid && stall < 3) begin
        bus.out_ready = 1'b0;
        if (stall == 0) held = {bus.ovf, bus.cout, bus.sum};
        else check("bp_hold", {bus.ovf, bus.cout, bus.sum}, held);
        stall++;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (!bus.out_ready) check("bp_in_ready", bus.in_ready, 0);
      else if (stall == 3) check("bp_no_gap", bus.out_valid, 1);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check("bp_result", {bus.ovf, bus.cout, bus.sum}, model(va[got], vb[got], vs[got], vc[got]));
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_count", got, 5);
    check("bp_stalls", stall, 3);
    #1;
    @(posedge clk); #1;
    check("bp_drained", bus.out_valid, 0);

    // Reset mid-flight: two beats in the pipe, then a one-cycle reset.
    bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h33; bus.b = 8'h44;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.a = 8'h55; bus.b = 8'h66;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_quiet", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    bus.a = 8'hA0; bus.b = 8'h0B; bus.sub = 1'b1; bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("mid_rst_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid_rst_lat1", bus.out_valid, 0);
    @(posedge clk); #1;
    check("mid_rst_lat2", bus.out_valid, 1);
    check("mid_rst_result", {bus.ovf, bus.cout, bus.sum}, {1'b0, 1'b1, 8'h94});
    @(posedge clk); #1;
    check("mid_rst_drained", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
